ahb_ext_waitmem: RTL and testbench
==================================

Name: ahb_ext_waitmem

Overview:
AHB-Lite subordinate memory that attaches to the SoC external bus port (HSELEXT window). It drives HRDATAEXT/HREADYEXT/HRESPEXT back into the SoC.
- Provides word-addressed SRAM storage with a programmable number of wait states.
- Returns a two-cycle ERROR response for out-of-range accesses.
- Lets benches exercise external-bus stall and error paths that tie-off stubs cannot.

Parameters:
AHBW, 64, data bus width in bits (32 or 64).
PA_BITS, 34, physical address width.
BASE, 'h8000_0000, byte base address of the memory window.
MEMWORDS_LOG2, 10, log2 of the number of AHBW-wide words stored.
WAITSTATES, 2, wait cycles inserted in each OKAY data phase (0..7).

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSELEXT  in  1  subordinate select from SoC decoder
HADDR  in  PA_BITS  address-phase byte address
HWDATA  in  AHBW  write data, valid in data phase
HWSTRB  in  AHBW/8  byte write strobes, valid in data phase
HWRITE  in  1  address-phase write indicator
HSIZE  in  3  transfer size (informational only)
HBURST  in  3  burst type (ignored; every beat is handled as SINGLE)
HTRANS  in  2  transfer type
HREADY  in  1  bus-wide ready (previous data phase complete)
HRDATAEXT  out  AHBW  read data
HREADYEXT  out  1  this subordinate's data-phase ready
HRESPEXT  out  1  0=OKAY, 1=ERROR

Behaviour:
- Clock HCLK only. HRESETn is asynchronous assert, synchronous deassert handled externally.
- Reset values:
  - FSM state = IDLE.
  - HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0.
  - Wait counter cleared.
  - Memory array is not reset.
- Accept rule: a transfer is accepted on a rising edge where HSELEXT & HREADY & HTRANS[1]. On acceptance, register:
  - word index addr_q = HADDR[MEMWORDS_LOG2+OFS-1:OFS], where OFS = log2(AHBW/8);
  - HWRITE into write_q;
  - in-range flag: BASE <= HADDR < BASE + 2^(MEMWORDS_LOG2+OFS).
- IDLE/BUSY transfers and unselected cycles are not accepted. The FSM stays in or returns to IDLE with a zero-wait OKAY.
- FSM states and transitions:
  - IDLE: HREADYEXT=1, HRESPEXT=0.
    - Accept & in-range & WAITSTATES>0 -> WAIT, with counter=WAITSTATES.
    - Accept & in-range & WAITSTATES==0 -> DATA.
    - Accept & out-of-range -> ERR1.
  - WAIT: HREADYEXT=0, HRESPEXT=0. Counter decrements each cycle. When the counter reaches 1, go to DATA.
  - DATA: HREADYEXT=1, HRESPEXT=0.
    - Write: on the edge ending DATA, mem[addr_q] byte lanes with HWSTRB[i]=1 take HWDATA[8i+7:8i]; other lanes are unchanged.
    - Read: HRDATAEXT = mem[addr_q] combinationally during DATA.
    - Next state follows the IDLE accept rule in the same cycle (pipelined back-to-back transfers), else IDLE.
  - ERR1: HREADYEXT=0, HRESPEXT=1. Always go to ERR2.
  - ERR2: HREADYEXT=1, HRESPEXT=1. No memory write. Next state follows the IDLE accept rule.
- HRDATAEXT is 0 in every state except a read DATA cycle.
- Latency: a read completes WAITSTATES+1 cycles after acceptance. Back-to-back throughput is 1/(WAITSTATES+1) beats per cycle.
- Read-after-write to the same word: the write commits at the edge ending its DATA. The following read's DATA is at least one cycle later and returns the new data. No bypass is required.
- HSIZE is ignored. HWSTRB is authoritative for byte lanes. A write with HWSTRB=0 performs no update and still returns OKAY.
- Reset asserted mid-transfer: the FSM returns immediately to IDLE with reset output values. An in-flight write is dropped (no partial commit).

Optional Feature:
EXTMEM_LFSR_WAIT_EN
- Defined:
  - Per-transfer wait count = lfsr[2:0] % (WAITSTATES+1), from an 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1.
  - The LFSR is seeded 8'hA5 at reset and advances once per accepted transfer.
  - A count of 0 goes directly to DATA.
- Undefined: fixed WAITSTATES as above, and no LFSR logic is present.

Test Plan:
1. Reset, then write 64'h0123_4567_89AB_CDEF to BASE+0x10 with HWSTRB=8'hFF, WAITSTATES=2 -> exactly 2 cycles of HREADYEXT=0, then 1 cycle HREADYEXT=1, HRESPEXT=0.
2. Read BASE+0x10 -> HRDATAEXT=64'h0123_4567_89AB_CDEF in the 3rd cycle after acceptance; HRDATAEXT=0 in the WAIT cycles.
3. Write 64'hFFFF_FFFF_FFFF_FFFF to BASE+0x10 with HWSTRB=8'h0F, then read it back -> 64'h0123_4567_FFFF_FFFF.
4. Read BASE-8 -> ERR1 (HREADYEXT=0, HRESPEXT=1) then ERR2 (HREADYEXT=1, HRESPEXT=1); memory is unchanged.
5. Back-to-back NONSEQ write then read to the same word with WAITSTATES=0 -> each beat is 1 cycle, and the read returns the just-written data.
6. Assert HRESETn=0 during WAIT of a write -> outputs are 1/0/0 immediately, and a later read shows the old value. With EXTMEM_LFSR_WAIT_EN and WAITSTATES=7, the first transfer waits 5 cycles (from seed 8'hA5).

Source files
------------

// File: rtl/ahb_ext_waitmem.sv
// ahb_ext_waitmem: AHB-Lite subordinate SRAM on the SoC external bus port.
// Word-addressed storage with a programmable number of wait states per OKAY
// data phase. Out-of-window accesses get a two-cycle ERROR response.
// Optional build macro EXTMEM_LFSR_WAIT_EN: when defined, each transfer's wait
// count is drawn from an 8-bit LFSR (lfsr[2:0] % (WAITSTATES+1)) instead of
// the fixed WAITSTATES value.
module ahb_ext_waitmem #(
  parameter int                 AHBW          = 64,
  parameter int                 PA_BITS       = 34,
  parameter logic [PA_BITS-1:0] BASE          = 'h8000_0000,
  parameter int                 MEMWORDS_LOG2 = 10,
  parameter int                 WAITSTATES    = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSELEXT,
  input  logic [PA_BITS-1:0]   HADDR,
  input  logic [AHBW-1:0]      HWDATA,
  input  logic [AHBW/8-1:0]    HWSTRB,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [1:0]           HTRANS,
  input  logic                 HREADY,
  output logic [AHBW-1:0]      HRDATAEXT,
  output logic                 HREADYEXT,
  output logic                 HRESPEXT
);

  localparam int NBYTES = AHBW / 8;
  localparam int OFS    = $clog2(NBYTES);
  localparam int DEPTH  = 1 << MEMWORDS_LOG2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // Window bounds carry one extra bit so BASE + size cannot wrap.
  localparam logic [PA_BITS:0] WIN_ONE  = 1;
  localparam logic [PA_BITS:0] WIN_LO   = {1'b0, BASE};
  localparam logic [PA_BITS:0] WIN_SIZE = WIN_ONE << (MEMWORDS_LOG2 + OFS);
  localparam logic [PA_BITS:0] WIN_HI   = WIN_LO + WIN_SIZE;

  logic [AHBW-1:0]          mem [0:DEPTH-1];

  logic [2:0]               state_reg, state_next;
  logic [2:0]               cnt_reg, cnt_next;
  logic [MEMWORDS_LOG2-1:0] addr_reg;
  logic                     write_reg;

  logic                     accept;
  logic                     accept_take;
  logic                     in_range;
  logic [2:0]               wait_load;
  logic [AHBW-1:0]          mem_rd;
  logic [AHBW-1:0]          merged;
  logic                     unused_ok;

  assign unused_ok = ^{HSIZE, HBURST, HTRANS[0]};

  assign accept   = HSELEXT & HREADY & HTRANS[1];
  assign in_range = ({1'b0, HADDR} >= WIN_LO) && ({1'b0, HADDR} < WIN_HI);
  // Only states that present HREADYEXT=1 may start a new address phase.
  assign accept_take = accept && (state_reg != ST_WAIT) && (state_reg != ST_ERR1);

`ifdef EXTMEM_LFSR_WAIT_EN
  logic [7:0] lfsr_reg;
  logic       lfsr_fb;

  // x^8+x^6+x^5+x^4+1 Fibonacci feedback
  assign lfsr_fb   = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign wait_load = 3'({1'b0, lfsr_reg[2:0]} % 4'(WAITSTATES + 1));

  // LFSR steps once for every accepted transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      lfsr_reg <= 8'hA5;
    else if (accept_take)
      lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
  end
`else
  assign wait_load = 3'(WAITSTATES);
`endif

  // Next-state and wait-count logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1)
          state_next = ST_DATA;
      end
      ST_ERR1: state_next = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all complete this cycle and may pipeline a new beat
        state_next = ST_IDLE;
        if (accept_take) begin
          if (!in_range) begin
            state_next = ST_ERR1;
          end else if (wait_load != 3'd0) begin
            state_next = ST_WAIT;
            cnt_next   = wait_load;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
    endcase
  end

  // FSM state, wait counter and captured address-phase controls
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept_take) begin
        addr_reg  <= HADDR[MEMWORDS_LOG2+OFS-1:OFS];
        write_reg <= HWRITE;
      end
    end
  end

  assign mem_rd = mem[addr_reg];

  // Byte-lane merge: strobed lanes take new data, others keep the stored byte
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign merged[8*gi +: 8] = HWSTRB[gi] ? HWDATA[8*gi +: 8] : mem_rd[8*gi +: 8];
    end
  endgenerate

  // Write commits on the edge that ends a write DATA phase; storage is not reset
  always_ff @(posedge HCLK) begin
    if (state_reg == ST_DATA && write_reg)
      mem[addr_reg] <= merged;
  end

  assign HREADYEXT = !((state_reg == ST_WAIT) || (state_reg == ST_ERR1));
  assign HRESPEXT  = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);
  assign HRDATAEXT = (state_reg == ST_DATA && !write_reg) ? mem_rd : '0;

endmodule

// File: tb/tb_ahb_ext_waitmem.sv
// Directed bench for ahb_ext_waitmem: fixed wait states, byte strobes, error
// window edges, pipelined zero-wait beats, reset mid-transfer, and the first
// wait counts with WAITSTATES=7 (5 then 2 when EXTMEM_LFSR_WAIT_EN is defined).
module tb_ahb_ext_waitmem;

  localparam logic [33:0] B = 34'h0_8000_0000;

`ifdef EXTMEM_LFSR_WAIT_EN
  localparam int EXP_C1 = 5;
  localparam int EXP_C2 = 2;
`else
  localparam int EXP_C1 = 7;
  localparam int EXP_C2 = 7;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  hsel;
  logic [33:0] haddr;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic        hready;

  logic [63:0] rdata_a, rdata_b, rdata_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        resp_a, resp_b, resp_c;
  logic [2:0]  rdy_v, resp_v;
  logic [63:0] rdata_v [3];

  int checks = 0;
  int errors = 0;

  assign rdy_v      = {rdy_c, rdy_b, rdy_a};
  assign resp_v     = {resp_c, resp_b, resp_a};
  assign rdata_v[0] = rdata_a;
  assign rdata_v[1] = rdata_b;
  assign rdata_v[2] = rdata_c;
  assign hready     = &rdy_v;

  ahb_ext_waitmem #(.WAITSTATES(2)) dut_a (
    .HCLK(clk), .HRESETn(rst_n), .HSELEXT(hsel[0]), .HADDR(haddr),
    .HWDATA(hwdata), .HWSTRB(hwstrb), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HTRANS(htrans), .HREADY(hready),
    .HRDATAEXT(rdata_a), .HREADYEXT(rdy_a), .HRESPEXT(resp_a)
  );

  ahb_ext_waitmem #(.WAITSTATES(0)) dut_b (
    .HCLK(clk), .HRESETn(rst_n), .HSELEXT(hsel[1]), .HADDR(haddr),
    .HWDATA(hwdata), .HWSTRB(hwstrb), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HTRANS(htrans), .HREADY(hready),
    .HRDATAEXT(rdata_b), .HREADYEXT(rdy_b), .HRESPEXT(resp_b)
  );

  ahb_ext_waitmem #(.WAITSTATES(7)) dut_c (
    .HCLK(clk), .HRESETn(rst_n), .HSELEXT(hsel[2]), .HADDR(haddr),
    .HWDATA(hwdata), .HWSTRB(hwstrb), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HTRANS(htrans), .HREADY(hready),
    .HRDATAEXT(rdata_c), .HREADYEXT(rdy_c), .HRESPEXT(resp_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete single transfer on DUT d, starting just after a rising edge.
  task automatic xfer(input int d, input logic [33:0] addr, input logic wr,
                      input logic [63:0] wdata, input logic [7:0] strb,
                      input int exp_waits, input logic exp_err,
                      input logic [63:0] exp_rdata, input string tag);
    int          n_low;
    logic        done;
    logic        low_resp;
    logic        wait_rd_nz;
    logic        fin_resp;
    logic [63:0] rd;
    n_low = 0; done = 1'b0; low_resp = 1'b0; wait_rd_nz = 1'b0;
    fin_resp = 1'b0; rd = '0;
    hsel   = 3'(1 << d);
    haddr  = addr;
    hwrite = wr;
    htrans = 2'b10;
    @(posedge clk); #1;
    hsel   = 3'b000;
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = wdata;
    hwstrb = strb;
    for (int k = 0; k < 32 && !done; k++) begin
      @(negedge clk);
      if (rdy_v[d]) begin
        done     = 1'b1;
        rd       = rdata_v[d];
        fin_resp = resp_v[d];
      end else begin
        n_low++;
        low_resp = low_resp | resp_v[d];
        if (rdata_v[d] !== 64'd0) wait_rd_nz = 1'b1;
      end
    end
    @(posedge clk); #1;
    hwdata = '0;
    hwstrb = '0;
    $display("xfer %-12s dut=%0d addr=%h wr=%0b wdata=%h strb=%h waits=%0d resp=%0b rdata=%h",
             tag, d, addr, wr, wdata, strb, n_low, fin_resp, rd);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_waits"}, 64'(n_low), 64'(exp_waits));
    chk({tag, "_resp"}, 64'(fin_resp), 64'(exp_err));
    chk({tag, "_stallresp"}, 64'(low_resp), 64'(exp_err));
    chk({tag, "_rdata"}, rd, (wr || exp_err) ? 64'd0 : exp_rdata);
    chk({tag, "_waitrdata"}, 64'(wait_rd_nz), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; hsel = '0; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
    hwdata = '0; hwstrb = '0; hsize = 3'd3; hburst = 3'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(rdy_v), 64'h7);
    chk("rst_resp", 64'(resp_v), 64'h0);
    chk("rst_rdata", rdata_v[0], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // IDLE and BUSY with select held are not accepted
    hsel = 3'b001; haddr = B + 34'h10; hwrite = 1'b1; htrans = 2'b00;
    @(posedge clk); #1;
    chk("idle_ready", 64'(rdy_a), 64'd1);
    htrans = 2'b01;
    @(posedge clk); #1;
    chk("busy_ready", 64'(rdy_a), 64'd1);
    chk("busy_resp", 64'(resp_a), 64'd0);
    $display("xfer idle/busy   dut=0 ready=%0b resp=%0b", rdy_a, resp_a);
    hsel = 3'b000; htrans = 2'b00; hwrite = 1'b0;

    // Fixed two wait states, full and partial strobes
    xfer(0, B + 34'h10, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 2, 1'b0, 64'd0, "wr_full");
    xfer(0, B + 34'h10, 1'b0, 64'd0, 8'h00, 2, 1'b0, 64'h0123_4567_89AB_CDEF, "rd_full");
    xfer(0, B + 34'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2, 1'b0, 64'd0, "wr_low");
    xfer(0, B + 34'h10, 1'b0, 64'd0, 8'h00, 2, 1'b0, 64'h0123_4567_FFFF_FFFF, "rd_low");

    // Window edges: just below BASE, just past the top (aliases word 2)
    xfer(0, B - 34'h8, 1'b0, 64'd0, 8'h00, 1, 1'b1, 64'd0, "rd_below");
    xfer(0, B + 34'h2010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1, 1'b1, 64'd0, "wr_above");
    xfer(0, B + 34'h10, 1'b0, 64'd0, 8'h00, 2, 1'b0, 64'h0123_4567_FFFF_FFFF, "rd_keep");
    xfer(0, B + 34'h1FF8, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 2, 1'b0, 64'd0, "wr_top");
    xfer(0, B + 34'h1FF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2, 1'b0, 64'd0, "wr_nostrb");
    xfer(0, B + 34'h1FF8, 1'b0, 64'd0, 8'h00, 2, 1'b0, 64'h1122_3344_5566_7788, "rd_top");

    // Reset asserted during the WAIT of a write drops the write
    hsel = 3'b001; haddr = B + 34'h10; hwrite = 1'b1; htrans = 2'b10;
    @(posedge clk); #1;
    hsel = 3'b000; htrans = 2'b00; hwrite = 1'b0;
    hwdata = 64'hDEAD_BEEF_DEAD_BEEF; hwstrb = 8'hFF;
    @(negedge clk);
    chk("mid_wait_ready", 64'(rdy_a), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(rdy_a), 64'd1);
    chk("mid_rst_resp", 64'(resp_a), 64'd0);
    chk("mid_rst_rdata", rdata_a, 64'd0);
    $display("xfer reset_mid   dut=0 ready=%0b resp=%0b rdata=%h", rdy_a, resp_a, rdata_a);
    @(posedge clk); #1;
    hwdata = '0; hwstrb = '0;
    rst_n = 1'b1;
    xfer(0, B + 34'h10, 1'b0, 64'd0, 8'h00, 2, 1'b0, 64'h0123_4567_FFFF_FFFF, "rd_postrst");

    // Zero-wait pipelined write then read of the same word
    hsel = 3'b010; haddr = B + 34'h20; hwrite = 1'b1; htrans = 2'b10;
    @(posedge clk); #1;
    hwdata = 64'hCAFE_F00D_1234_5678; hwstrb = 8'hFF;
    haddr = B + 34'h20; hwrite = 1'b0; htrans = 2'b10;
    @(negedge clk);
    chk("b2b_wr_ready", 64'(rdy_b), 64'd1);
    chk("b2b_wr_resp", 64'(resp_b), 64'd0);
    chk("b2b_wr_rdata", rdata_b, 64'd0);
    @(posedge clk); #1;
    hsel = 3'b000; htrans = 2'b00; hwdata = '0; hwstrb = '0;
    @(negedge clk);
    chk("b2b_rd_ready", 64'(rdy_b), 64'd1);
    chk("b2b_rd_resp", 64'(resp_b), 64'd0);
    chk("b2b_rd_rdata", rdata_b, 64'hCAFE_F00D_1234_5678);
    $display("xfer b2b         dut=1 ready=%0b resp=%0b rdata=%h", rdy_b, resp_b, rdata_b);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_idle_rdata", rdata_b, 64'd0);
    @(posedge clk); #1;

    // WAITSTATES=7 instance: first two transfers after reset
    xfer(2, B + 34'h8, 1'b1, 64'h5A5A_5A5A_0000_FFFF, 8'hFF, EXP_C1, 1'b0, 64'd0, "c_first");
    xfer(2, B + 34'h8, 1'b0, 64'd0, 8'h00, EXP_C2, 1'b0, 64'h5A5A_5A5A_0000_FFFF, "c_second");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
